// File: rtl/mux_rr_mnton_if.sv
// -----------------------------------------------------------------------------
// mux_rr_mnton_if
// Bus bundle for the registered M:1 selector.
//   enable  : 1 = new grants allowed, 0 = hold (output may still drain)
//   mode    : 0 = static select via S, 1 = round-robin
//   S       : channel select (static mode only)
//   I       : packed channel data, channel k is I[k*N +: N]
//   I_valid : per-channel request
//   I_ready : per-channel grant (one-hot or zero, combinational)
//   O       : registered output word
//   O_valid : O holds an unconsumed word
//   O_ready : downstream accepts O this cycle
//   ptr     : round-robin priority pointer (debug)
// Modports: master = traffic source/sink side, slave = selector side.
// -----------------------------------------------------------------------------
interface mux_rr_mnton_if #(
    parameter int N = 24,
    parameter int M = 8
);
    localparam int SEL_W = $clog2(M);

    logic             enable;
    logic             mode;
    logic [SEL_W-1:0] S;
    logic [M*N-1:0]   I;
    logic [M-1:0]     I_valid;
    logic [M-1:0]     I_ready;
    logic [N-1:0]     O;
    logic             O_valid;
    logic             O_ready;
    logic [SEL_W-1:0] ptr;

    modport master (
        output enable, mode, S, I, I_valid, O_ready,
        input  I_ready, O, O_valid, ptr
    );

    modport slave (
        input  enable, mode, S, I, I_valid, O_ready,
        output I_ready, O, O_valid, ptr
    );
endinterface

// File: rtl/mux_rr_mnton.sv
// -----------------------------------------------------------------------------
// mux_rr_mnton
// Registered M:1 datapath selector with per-channel valid/ready handshake and a
// flow-controlled one-word output register. Channel choice is either a static
// select (S) or round-robin starting from ptr.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous, active-low reset
//   bus : mux_rr_mnton_if.slave (see interface header for signal list)
// -----------------------------------------------------------------------------
module mux_rr_mnton #(
    parameter int N = 24,
    parameter int M = 8
) (
    input  logic              clk,
    input  logic              rst,
    mux_rr_mnton_if.slave     bus
);
    localparam int SEL_W = $clog2(M);

    logic [N-1:0]     r_o;
    logic             r_o_valid;
    logic [SEL_W-1:0] r_ptr;

    logic [N-1:0]     w_chan [M];
    logic             w_slot_free;
    logic             w_s_in_range;
    logic             w_static_valid;
    logic             w_rr_found;
    logic [SEL_W-1:0] w_rr_idx;
    logic [SEL_W-1:0] w_sel_idx;
    logic             w_sel_valid;
    logic             w_grant;
    logic [SEL_W-1:0] w_ptr_next;

    // Channel index ptr+off, wrapped modulo M (M need not be a power of 2).
    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] base,
                                                input int off);
        int s;
        s = int'(base) + off;
        if (s >= M) s = s - M;
        return SEL_W'(s);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < M; gi++) begin : g_chan
            assign w_chan[gi]       = bus.I[gi*N +: N];
            assign bus.I_ready[gi]  = w_grant && (w_sel_idx == SEL_W'(gi));
        end
    endgenerate

    assign w_slot_free    = !r_o_valid || bus.O_ready;
    assign w_s_in_range   = (int'(bus.S) < M);
    assign w_static_valid = w_s_in_range ? bus.I_valid[bus.S] : 1'b0;

    // First requesting channel at or after ptr, wrapping.
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int off = 0; off < M; off++) begin
            if (!w_rr_found && bus.I_valid[rr_idx(r_ptr, off)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = rr_idx(r_ptr, off);
            end
        end
    end

    assign w_sel_idx   = bus.mode ? w_rr_idx   : bus.S;
    assign w_sel_valid = bus.mode ? w_rr_found : w_static_valid;

    // A grant is always a transfer: the selected channel is known to be valid.
    assign w_grant     = rst && bus.enable && w_slot_free && w_sel_valid;
    assign w_ptr_next  = (int'(w_sel_idx) == M - 1) ? '0 : w_sel_idx + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_o       <= '0;
            r_o_valid <= 1'b0;
            r_ptr     <= '0;
        end else begin
            if (w_grant) begin
                // Load (possibly replacing a word drained this same cycle).
                r_o       <= w_chan[w_sel_idx];
                r_o_valid <= 1'b1;
                if (bus.mode) r_ptr <= w_ptr_next;
            end else if (bus.O_ready) begin
                r_o_valid <= 1'b0;
            end
        end
    end

    assign bus.O       = r_o;
    assign bus.O_valid = r_o_valid;
    assign bus.ptr     = r_ptr;
endmodule

// File: tb/tb_mux_rr_mnton.sv
module tb_mux_rr_mnton;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_rr_mnton_if #(.N(24), .M(8)) if8 ();
    mux_rr_mnton_if #(.N(24), .M(5)) if5 ();

    mux_rr_mnton #(.N(24), .M(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    mux_rr_mnton #(.N(24), .M(5)) dut5 (.clk(clk), .rst(rst), .bus(if5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp8();
        for (int k = 0; k < 8; k++) if8.I[k*24 +: 24] = 24'hC00000 + 24'(k);
    endtask

    task automatic load_ramp5();
        for (int k = 0; k < 5; k++) if5.I[k*24 +: 24] = 24'h500000 + 24'(k);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        if8.I_valid = 8'hFF; if5.I_valid = 5'h1F;
        step(); step();
        checks++; if (if8.I_ready !== 8'h00) begin errors++; $display("FAIL reset_ready got %h exp 00", if8.I_ready); end
        checks++; if (if8.O !== 24'h0) begin errors++; $display("FAIL reset_O got %h exp 000000", if8.O); end
        checks++; if (if8.O_valid !== 1'b0) begin errors++; $display("FAIL reset_Ovalid got %b exp 0", if8.O_valid); end
        checks++; if (if8.ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr got %0d exp 0", if8.ptr); end
        checks++; if (if5.ptr !== 3'd0 || if5.O_valid !== 1'b0) begin errors++; $display("FAIL reset_m5 got ptr %0d ov %b exp 0 0", if5.ptr, if5.O_valid); end
        rst = 1'b1;
        if8.I_valid = 8'h00; if5.I_valid = 5'h00;
        #1;
    endtask

    task automatic test_static_select();
        load_ramp8();
        if8.I[5*24 +: 24] = 24'hABCDEF;
        if8.mode = 1'b0; if8.S = 3'd5; if8.I_valid = 8'hFF; if8.O_ready = 1'b1;
        #1;
        checks++; if (if8.I_ready !== 8'h20) begin errors++; $display("FAIL static_ready got %h exp 20", if8.I_ready); end
        step();
        checks++; if (if8.O !== 24'hABCDEF || if8.O_valid !== 1'b1) begin errors++; $display("FAIL static_O got %h/%b exp abcdef/1", if8.O, if8.O_valid); end
        checks++; if (if8.ptr !== 3'd0) begin errors++; $display("FAIL static_ptr got %0d exp 0", if8.ptr); end
        if8.I_valid = 8'h00;
        step();
        checks++; if (if8.O_valid !== 1'b0 || if8.O !== 24'hABCDEF) begin errors++; $display("FAIL static_drain got %h/%b exp abcdef/0", if8.O, if8.O_valid); end
    endtask

    task automatic test_rr_fairness();
        logic [7:0] exp_rdy8;
        logic [4:0] exp_rdy5;
        load_ramp8();
        if8.mode = 1'b1; if8.I_valid = 8'hFF; if8.O_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            #1;
            exp_rdy8 = 8'd1 << (c % 8);
            checks++; if (if8.I_ready !== exp_rdy8) begin errors++; $display("FAIL rr8_ready[%0d] got %h exp %h", c, if8.I_ready, exp_rdy8); end
            step();
            checks++; if (if8.O !== 24'hC00000 + 24'(c % 8) || if8.ptr !== 3'((c % 8 + 1) % 8)) begin
                errors++; $display("FAIL rr8_out[%0d] got %h ptr %0d exp %h ptr %0d", c, if8.O, if8.ptr, 24'hC00000 + 24'(c % 8), (c % 8 + 1) % 8);
            end
        end
        if8.I_valid = 8'h00;
        step();
        load_ramp5();
        if5.enable = 1'b1; if5.mode = 1'b1; if5.I_valid = 5'h1F; if5.O_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_rdy5 = 5'd1 << (c % 5);
            checks++; if (if5.I_ready !== exp_rdy5) begin errors++; $display("FAIL rr5_ready[%0d] got %h exp %h", c, if5.I_ready, exp_rdy5); end
            step();
            checks++; if (if5.O !== 24'h500000 + 24'(c % 5) || if5.ptr !== 3'((c % 5 + 1) % 5)) begin
                errors++; $display("FAIL rr5_out[%0d] got %h ptr %0d exp %h ptr %0d", c, if5.O, if5.ptr, 24'h500000 + 24'(c % 5), (c % 5 + 1) % 5);
            end
        end
        if5.I_valid = 5'h00;
        step();
    endtask

    task automatic test_sparse();
        logic [7:0] exp_rdy [3];
        logic [2:0] exp_ptr [3];
        exp_rdy = '{8'h01, 8'h04, 8'h01};
        exp_ptr = '{3'd1, 3'd3, 3'd1};
        // Move ptr from 1 to 6 with a single grant on channel 5.
        if8.mode = 1'b1; if8.O_ready = 1'b1; if8.I_valid = 8'b0010_0000;
        step();
        checks++; if (if8.ptr !== 3'd6) begin errors++; $display("FAIL sparse_setup_ptr got %0d exp 6", if8.ptr); end
        if8.I_valid = 8'b0000_0101;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (if8.I_ready !== exp_rdy[c]) begin errors++; $display("FAIL sparse_ready[%0d] got %h exp %h", c, if8.I_ready, exp_rdy[c]); end
            step();
            checks++; if (if8.ptr !== exp_ptr[c]) begin errors++; $display("FAIL sparse_ptr[%0d] got %0d exp %0d", c, if8.ptr, exp_ptr[c]); end
        end
        if8.I_valid = 8'h00;
        step();
    endtask

    task automatic test_back_to_back();
        // ptr is 1 here: first grant goes to channel 1, then hold 3 cycles.
        load_ramp8();
        if8.mode = 1'b1; if8.I_valid = 8'hFF; if8.O_ready = 1'b0;
        step();
        checks++; if (if8.O !== 24'hC00001 || if8.O_valid !== 1'b1 || if8.ptr !== 3'd2) begin
            errors++; $display("FAIL bp_load got %h/%b ptr %0d exp c00001/1 ptr 2", if8.O, if8.O_valid, if8.ptr);
        end
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (if8.I_ready !== 8'h00) begin errors++; $display("FAIL bp_ready[%0d] got %h exp 00", c, if8.I_ready); end
            step();
            checks++; if (if8.O !== 24'hC00001 || if8.O_valid !== 1'b1 || if8.ptr !== 3'd2) begin
                errors++; $display("FAIL bp_hold[%0d] got %h/%b ptr %0d exp c00001/1 ptr 2", c, if8.O, if8.O_valid, if8.ptr);
            end
        end
        if8.O_ready = 1'b1;
        #1;
        checks++; if (if8.I_ready !== 8'h04) begin errors++; $display("FAIL bp_release_ready got %h exp 04", if8.I_ready); end
        step();
        checks++; if (if8.O !== 24'hC00002 || if8.O_valid !== 1'b1 || if8.ptr !== 3'd3) begin
            errors++; $display("FAIL bp_reload got %h/%b ptr %0d exp c00002/1 ptr 3", if8.O, if8.O_valid, if8.ptr);
        end
        if8.I_valid = 8'h00;
        step();
    endtask

    task automatic test_enable_range_reset();
        // Load channel 3 (ptr 3) and hold it.
        if8.I_valid = 8'hFF; if8.O_ready = 1'b0;
        step();
        checks++; if (if8.O !== 24'hC00003 || if8.ptr !== 3'd4) begin errors++; $display("FAIL en_load got %h ptr %0d exp c00003 ptr 4", if8.O, if8.ptr); end
        if8.enable = 1'b0; if8.O_ready = 1'b1;
        #1;
        checks++; if (if8.I_ready !== 8'h00) begin errors++; $display("FAIL en_ready got %h exp 00", if8.I_ready); end
        step();
        checks++; if (if8.O_valid !== 1'b0 || if8.ptr !== 3'd4 || if8.O !== 24'hC00003) begin
            errors++; $display("FAIL en_drain got %h/%b ptr %0d exp c00003/0 ptr 4", if8.O, if8.O_valid, if8.ptr);
        end
        step();
        checks++; if (if8.O_valid !== 1'b0 || if8.I_ready !== 8'h00) begin errors++; $display("FAIL en_idle got %b/%h exp 0/00", if8.O_valid, if8.I_ready); end

        // Out-of-range static select on the 5-channel instance.
        load_ramp5();
        if5.mode = 1'b0; if5.S = 3'd6; if5.I_valid = 5'h1F; if5.O_ready = 1'b1;
        #1;
        checks++; if (if5.I_ready !== 5'h00) begin errors++; $display("FAIL range_ready got %h exp 00", if5.I_ready); end
        step();
        checks++; if (if5.O_valid !== 1'b0) begin errors++; $display("FAIL range_Ovalid got %b exp 0", if5.O_valid); end
        if5.S = 3'd4;
        #1;
        checks++; if (if5.I_ready !== 5'h10) begin errors++; $display("FAIL range4_ready got %h exp 10", if5.I_ready); end
        step();
        checks++; if (if5.O !== 24'h500004 || if5.O_valid !== 1'b1 || if5.ptr !== 3'd1) begin
            errors++; $display("FAIL range4_out got %h/%b ptr %0d exp 500004/1 ptr 1", if5.O, if5.O_valid, if5.ptr);
        end
        if5.I_valid = 5'h00;

        // Mid-operation reset drops the held word and clears ptr.
        if8.enable = 1'b1; if8.mode = 1'b1; if8.I_valid = 8'hFF; if8.O_ready = 1'b0;
        step();
        checks++; if (if8.O_valid !== 1'b1 || if8.ptr !== 3'd5) begin errors++; $display("FAIL mrst_load got %b ptr %0d exp 1 ptr 5", if8.O_valid, if8.ptr); end
        rst = 1'b0;
        #1;
        checks++; if (if8.I_ready !== 8'h00) begin errors++; $display("FAIL mrst_ready got %h exp 00", if8.I_ready); end
        step();
        checks++; if (if8.O_valid !== 1'b0 || if8.ptr !== 3'd0 || if8.O !== 24'h0) begin
            errors++; $display("FAIL mrst_state got %h/%b ptr %0d exp 000000/0 ptr 0", if8.O, if8.O_valid, if8.ptr);
        end
        rst = 1'b1;
        if8.I_valid = 8'h00;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        if8.enable = 1'b1; if8.mode = 1'b0; if8.S = '0; if8.I = '0; if8.I_valid = '0; if8.O_ready = 1'b1;
        if5.enable = 1'b1; if5.mode = 1'b0; if5.S = '0; if5.I = '0; if5.I_valid = '0; if5.O_ready = 1'b1;
        #2;
        test_reset();
        test_static_select();
        test_rr_fairness();
        test_sparse();
        test_back_to_back();
        test_enable_range_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
